// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode and FSM state encodings shared by the seq_alu block
package seq_alu_pkg;
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_MOD = 3'b011;
   localparam logic [2:0] OP_DIV = 3'b100;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: W-step unsigned shift-add multiplier and restoring divider
module seq_alu_iter #(parameter int W = 3) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_start,
   input  logic           i_mode,
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   output logic [2*W-1:0] o_prod,
   output logic [W-1:0]   o_quo,
   output logic [W-1:0]   o_rem,
   output logic           o_done
);
   localparam int CW = $clog2(W + 1);
   logic [2*W-1:0] r_acc;
   logic [W-1:0]   r_b;
   logic           r_mode;
   logic           r_busy;
   logic [CW-1:0]  r_cnt;
   logic [W:0]     w_sum;
   logic [W:0]     w_diff;
   logic [2*W-1:0] w_mul;
   logic [2*W-1:0] w_div;
   always_comb begin
      w_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_acc[0] ? r_b : {W{1'b0}}};
      w_mul  = {w_sum, r_acc[W-1:1]};
      w_diff = {1'b0, r_acc[2*W-2:W-1]} - {1'b0, r_b};
      w_div  = w_diff[W] ? {r_acc[2*W-2:0], 1'b0} : {w_diff[W-1:0], r_acc[W-2:0], 1'b1};
   end
   assign o_done = r_busy && (r_cnt == CW'(W - 1));
   assign o_prod = r_acc;
   assign o_quo  = r_acc[W-1:0];
   assign o_rem  = r_acc[2*W-1:W];
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc  <= '0;
         r_b    <= '0;
         r_mode <= 1'b0;
         r_busy <= 1'b0;
         r_cnt  <= '0;
      end else if (i_start) begin
         r_acc  <= {{W{1'b0}}, i_a};
         r_b    <= i_b;
         r_mode <= i_mode;
         r_busy <= 1'b1;
         r_cnt  <= '0;
      end else if (r_busy) begin
         r_acc  <= r_mode ? w_div : w_mul;
         r_cnt  <= r_cnt + CW'(1);
         r_busy <= !o_done;
      end
   end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked multi-cycle signed ALU with add/sub/mul/div/mod and flags
module seq_alu
   import seq_alu_pkg::*;
#(parameter int W = 3) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   input  logic [2:0]     S,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [2*W-1:0] R,
   output logic           SF,
   output logic           ZF,
   output logic           DZF,
   output logic           out_valid,
   input  logic           out_ready
);
   logic [1:0]     r_state;
   logic [2:0]     r_op;
   logic           r_neg;
   logic [2*W-1:0] r_r;
   logic           r_sf;
   logic           r_zf;
   logic           r_dzf;
   logic           w_acc;
   logic           w_divop;
   logic           w_bz;
   logic           w_long;
   logic           w_load;
   logic           w_done;
   logic [W-1:0]   w_ma;
   logic [W-1:0]   w_mb;
   logic [2*W-1:0] w_ea;
   logic [2*W-1:0] w_eb;
   logic [2*W-1:0] w_fast;
   logic [2*W-1:0] w_mag;
   logic [2*W-1:0] w_res;
   logic [2*W-1:0] w_prod;
   logic [W-1:0]   w_quo;
   logic [W-1:0]   w_rem;
   logic [1:0]     w_next;
   seq_alu_iter #(.W(W)) u_iter (
      .clk(clk), .rst(rst), .i_start(w_acc && w_long), .i_mode(S != OP_MUL),
      .i_a(w_ma), .i_b(w_mb), .o_prod(w_prod), .o_quo(w_quo), .o_rem(w_rem), .o_done(w_done)
   );
   always_comb begin
      w_acc   = in_valid && in_ready;
      w_divop = (S == OP_MOD) || (S == OP_DIV);
      w_bz    = (B == '0);
      w_long  = (S == OP_MUL) || (w_divop && !w_bz);
      w_ma    = A[W-1] ? -A : A;
      w_mb    = B[W-1] ? -B : B;
      w_ea    = {{W{A[W-1]}}, A};
      w_eb    = {{W{B[W-1]}}, B};
      w_fast  = (S == OP_ADD) ? w_ea + w_eb : (S == OP_SUB) ? w_ea - w_eb : '0;
      w_mag   = (r_op == OP_MUL) ? w_prod : (r_op == OP_DIV) ? {{W{1'b0}}, w_quo} : {{W{1'b0}}, w_rem};
      w_res   = (r_state == FIX) ? (r_neg ? -w_mag : w_mag) : w_fast;
      w_load  = (w_acc && !w_long) || (r_state == FIX);
      w_next  = (r_state == IDLE) ? (w_acc ? (w_long ? CALC : DONE) : IDLE) :
                (r_state == CALC) ? (w_done ? FIX : CALC) :
                (r_state == FIX)  ? DONE : (out_ready ? IDLE : DONE);
   end
   assign in_ready  = (r_state == IDLE) && !rst;
   assign out_valid = (r_state == DONE);
   assign R   = r_r;
   assign SF  = r_sf;
   assign ZF  = r_zf;
   assign DZF = r_dzf;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_op    <= OP_ADD;
         r_neg   <= 1'b0;
         r_r     <= '0;
         r_sf    <= 1'b0;
         r_zf    <= 1'b0;
         r_dzf   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_op  <= S;
            r_neg <= (S == OP_MOD) ? A[W-1] : A[W-1] ^ B[W-1];
         end
         if (w_load) begin
            r_r   <= w_res;
            r_sf  <= w_res[2*W-1];
            r_zf  <= (w_res == '0);
            r_dzf <= (r_state != FIX) && w_divop && w_bz;
         end
      end
   end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle signed ALU; successor to the 3-bit combinational Alu. Accepts W-bit two's-complement operands through a valid/ready handshake and performs add, sub, mul, div and mod. Mul/div/mod use an iterative shift datapath with a fixed latency. Result is 2W bits wide with sign, zero and divide-by-zero flags, held until consumed downstream.

## Interface
- W, default 3: operand width in bits, two's complement, W >= 2.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- A  in  W  signed operand A, sampled on accept.
- B  in  W  signed operand B, sampled on accept.
- S  in  3  opcode: 000 add, 001 sub, 010 mul, 011 mod, 100 div, 101–111 illegal.
- in_valid  in  1  A/B/S valid.
- in_ready  out  1  block can accept; high only in IDLE and never while rst is high.
- R  out  2W  signed result, sign-extended to 2W.
- SF  out  1  R[2W-1].
- ZF  out  1  R == 0.
- DZF  out  1  div/mod attempted with B == 0.
- out_valid  out  1  R/flags valid.
- out_ready  in  1  consumer accepts result.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- Accept is in_valid && in_ready at a rising edge. Only one operation is outstanding at a time.
- IDLE to DONE, at accept, for add/sub, illegal opcode, or div/mod with B == 0. R is computed and registered at this edge.
- IDLE to CALC, at accept, for mul/div/mod with B != 0. This edge latches the operand magnitudes, the result sign and the opcode, and clears the iteration counter.
- CALC runs exactly W iterations, one per cycle: shift-add for mul, restoring for div/mod, on unsigned W-bit magnitudes. After the W-th iteration it moves to FIX.
- FIX applies the sign correction, registers R and the flags, then moves to DONE.
- DONE holds out_valid=1 with R and the flags stable. On out_ready it moves to IDLE.
- Arithmetic rules:
  - add/sub: operands sign-extended to 2W; exact, no overflow possible.
  - mul: full 2W-bit signed product.
  - div: quotient truncated toward zero. -2^(W-1) / -1 = +2^(W-1), exact in 2W bits.
  - mod: remainder takes the sign of A, so |R| < |B|.
- Divide by zero: R = 0, DZF = 1, ZF = 1, SF = 0.
- Illegal opcode: R = 0, ZF = 1, DZF = 0, SF = 0.
- DZF is 0 for every operation other than a div/mod by zero.
- Inputs A/B/S are ignored outside the accept edge, so changing them during CALC has no effect.

## Timing
- Latency is counted from the accept edge to the first edge at which out_valid is sampled high.
  - 1 cycle: add/sub, illegal opcode, div/mod by zero.
  - W+2 cycles: mul/div/mod.
- out_ready may already be high when DONE is entered; the result then completes in that cycle.
- After a result completes, the next accept is possible one cycle later, from IDLE.
- out_ready is ignored outside DONE.
- Backpressure: while out_ready = 0, R/SF/ZF/DZF/out_valid hold indefinitely and in_ready stays 0.
- Reset values: state IDLE, R = 0, SF = ZF = DZF = 0, out_valid = 0, in_ready = 0 while rst is high and 1 on the first cycle after rst deasserts.
- Reset mid-operation (in CALC, FIX or DONE): the operation is aborted, no out_valid is produced, and the block returns to IDLE.

## Structure
- seq_alu_pkg holds:
  - opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_MOD, OP_DIV;
  - the state encoding IDLE/CALC/FIX/DONE.
- Sub-module seq_alu_iter: the W-iteration magnitude engine (shift-add multiply and restoring divide).
  - Inputs: start, mode, |A|, |B|.
  - Outputs: product, quotient and remainder magnitudes, plus a done pulse.
- The top level owns the handshake, the FSM, sign handling and the flags.

## Test plan
- W=3, add A=-4, B=-4: R = 6'b111000, SF=1, ZF=0, out_valid at latency 1.
- W=3, mul A=3, B=-2: R = 6'b111010 (-6), SF=1, latency 5. Also mul A=-4, B=-4: R = 6'b010000 (16).
- W=3, mod A=-3, B=2: R = -1 (6'b111111). Div A=-4, B=-1: R = 6'b000100. Both at latency 5, DZF=0.
- W=3, mod A=2, B=0: R = 0, DZF=1, ZF=1, SF=0, latency 1. Then add A=1, B=1: R=2, DZF=0.
- Backpressure: hold out_ready=0 for 4 cycles after out_valid. R and flags stay stable and in_ready=0. A new in_valid is not accepted until the cycle after the out_ready handshake.
- Reset and exhaustive checks:
  - Assert rst on the 2nd cycle of CALC: no out_valid, all outputs 0, in_ready=1 one cycle after rst falls.
  - Exhaustive W=3 sweep of all A, B and S against a behavioural model.
  - Random W=8 sweep including -128/-1 and -128%-1 = 0.
